// File: rtl/cheshire_fan_ctrl.sv
// Board fan controller: debounced switches -> duty target -> ramped PWM.
// Optional tach measurement is built when FAN_CTRL_TACH_EN is defined.
module cheshire_fan_ctrl #(
  parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
  parameter int unsigned PWM_FREQ_HZ     = 25_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned RAMP_PERIODS    = 4,
  parameter int unsigned TACH_WINDOW     = CLK_FREQ_HZ
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] fan_sw_i,
  output logic       fan_pwm_o,
  output logic [7:0] duty_o,
  output logic       ramp_busy_o
`ifdef FAN_CTRL_TACH_EN
  ,
  input  logic        tach_i,
  output logic [15:0] tach_count_o,
  output logic        tach_valid_o
`endif
);

  localparam int unsigned DIV_RAW = CLK_FREQ_HZ / (PWM_FREQ_HZ * 256);
  localparam int unsigned DIV = (DIV_RAW > 0) ? DIV_RAW : 1;
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_PERIODS - 1);

  logic [3:0]    sw_s1_q, sw_s2_q;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d, db_inc;
  logic [3:0]    sw_db_q, sw_db_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic [7:0]    target;
  logic          tick, period_end;

  // Switch debounce: accept the candidate once it has been stable long enough
  always_comb begin
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    sw_db_d  = sw_db_q;
    db_inc   = db_cnt_q + CW'(1);
    if (sw_s2_q != cand_q) begin
      cand_d   = sw_s2_q;
      db_cnt_d = '0;
    end else begin
      if (db_cnt_q != DB_LAST) db_cnt_d = db_inc;
      if (db_inc >= DB_LAST) sw_db_d = cand_q;
    end
  end

  // 0x0..0xF maps onto 0..255 in steps of 17
  assign target = {sw_db_q, sw_db_q};

  assign tick       = (div_q == DIV_LAST);
  assign period_end = tick & (pwm_cnt_q == 8'hFF);

  // Prescaler, PWM counter, duty ramp and registered PWM compare
  always_comb begin
    div_d      = tick ? '0 : div_q + DW'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    duty_d     = duty_q;
    if (period_end) begin
      if (ramp_cnt_q == RAMP_LAST) begin
        ramp_cnt_d = '0;
        if (duty_q < target)      duty_d = duty_q + 8'd1;
        else if (duty_q > target) duty_d = duty_q - 8'd1;
      end else begin
        ramp_cnt_d = ramp_cnt_q + RW'(1);
      end
    end
    pwm_d = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
  end

  // State registers for the switch path and PWM engine
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      cand_q     <= '0;
      db_cnt_q   <= '0;
      sw_db_q    <= '0;
      div_q      <= '0;
      pwm_cnt_q  <= '0;
      ramp_cnt_q <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
    end else begin
      sw_s1_q    <= fan_sw_i;
      sw_s2_q    <= sw_s1_q;
      cand_q     <= cand_d;
      db_cnt_q   <= db_cnt_d;
      sw_db_q    <= sw_db_d;
      div_q      <= div_d;
      pwm_cnt_q  <= pwm_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
    end
  end

  assign fan_pwm_o   = pwm_q;
  assign duty_o      = duty_q;
  assign ramp_busy_o = (duty_q != target);

`ifdef FAN_CTRL_TACH_EN
  localparam int unsigned WW = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(TACH_WINDOW - 1);

  logic          t_s1_q, t_s2_q, t_s3_q;
  logic [WW-1:0] win_q, win_d;
  logic [15:0]   edge_cnt_q, edge_cnt_d, edge_sum;
  logic [15:0]   tach_cnt_q, tach_cnt_d;
  logic          tach_vld_q, tach_vld_d;
  logic          t_rise;

  assign t_rise = t_s2_q & ~t_s3_q;

  // Saturating edge count per window, published on the window's last cycle
  always_comb begin
    edge_sum   = edge_cnt_q;
    if (t_rise && edge_cnt_q != 16'hFFFF) edge_sum = edge_cnt_q + 16'd1;
    win_d      = win_q + WW'(1);
    edge_cnt_d = edge_sum;
    tach_cnt_d = tach_cnt_q;
    tach_vld_d = 1'b0;
    if (win_q == WIN_LAST) begin
      win_d      = '0;
      edge_cnt_d = '0;
      tach_cnt_d = edge_sum;
      tach_vld_d = 1'b1;
    end
  end

  // Tach synchroniser and measurement registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      t_s1_q     <= 1'b0;
      t_s2_q     <= 1'b0;
      t_s3_q     <= 1'b0;
      win_q      <= '0;
      edge_cnt_q <= '0;
      tach_cnt_q <= '0;
      tach_vld_q <= 1'b0;
    end else begin
      t_s1_q     <= tach_i;
      t_s2_q     <= t_s1_q;
      t_s3_q     <= t_s2_q;
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      tach_cnt_q <= tach_cnt_d;
      tach_vld_q <= tach_vld_d;
    end
  end

  assign tach_count_o = tach_cnt_q;
  assign tach_valid_o = tach_vld_q;
`endif

endmodule
